// File: rtl/fpu_result_collector.sv
// Registered FPU result collector: decodes the issued opcode to a result unit,
// waits for that unit's valid pulse (or a timeout), then holds the selected
// result on a valid/ready port until writeback consumes it.
module fpu_result_collector #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_UNITS = 6,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ISSUE_VALID,
  input  logic [3:0]                FPU_Control,
  output logic                      ISSUE_READY,
  input  logic [N_UNITS*DATA_W-1:0] UNIT_DATA,
  input  logic [N_UNITS-1:0]        UNIT_VALID,
  output logic [DATA_W-1:0]         OUT,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic                      ILLEGAL,
  output logic                      TIMEOUT_ERR
);

  localparam int unsigned SEL_W = $clog2(N_UNITS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                ill_q, ill_d;
  logic                terr_q, terr_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;

  logic [SEL_W-1:0]    dec_unit_c;
  logic                dec_legal_c;
  logic [DATA_W-1:0]   unit_bus_c [N_UNITS];
  logic [DATA_W-1:0]   sel_data_c;
  logic                sel_valid_c;

  // Opcode to result-unit decode; opcodes 14/15 only exist on wider builds
  always_comb begin
    dec_unit_c  = '0;
    dec_legal_c = 1'b1;
    case (FPU_Control)
      4'd0, 4'd1:                 dec_unit_c = SEL_W'(0);
      4'd2:                       dec_unit_c = SEL_W'(1);
      4'd3:                       dec_unit_c = SEL_W'(2);
      4'd4, 4'd5, 4'd6:           dec_unit_c = SEL_W'(3);
      4'd7, 4'd8, 4'd9, 4'd10:    dec_unit_c = SEL_W'(4);
      4'd11, 4'd12, 4'd13:        dec_unit_c = SEL_W'(5);
      4'd14: begin
        if (N_UNITS >= 7) dec_unit_c = SEL_W'(6);
        else              dec_legal_c = 1'b0;
      end
      default: begin
        if (N_UNITS == 8) dec_unit_c = SEL_W'(7);
        else              dec_legal_c = 1'b0;
      end
    endcase
  end

  // Split the flat result bus into per-unit lanes
  always_comb begin
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      unit_bus_c[i] = UNIT_DATA[i*DATA_W +: DATA_W];
    end
  end

  assign sel_data_c  = unit_bus_c[sel_q];
  assign sel_valid_c = UNIT_VALID[sel_q];

  // Next-state and datapath loads
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ill_d   = ill_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        if (ISSUE_VALID && ready_q) begin
          if (dec_legal_c) begin
            sel_d   = dec_unit_c;
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            out_d   = '0;
            ill_d   = 1'b1;
            terr_d  = 1'b0;
            state_d = S_HOLD;
          end
        end
      end
      S_WAIT: begin
        // Saturating counter; the state always leaves WAIT when it tops out
        cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
        if (sel_valid_c) begin
          out_d   = sel_data_c;
          ill_d   = 1'b0;
          terr_d  = 1'b0;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          out_d   = '0;
          ill_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Handshake outputs registered from the next state, no input-to-output path
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_HOLD);
  end

  // State and datapath registers; ready stays low until the first edge after reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ill_q   <= 1'b0;
      terr_q  <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ill_q   <= ill_d;
      terr_q  <= terr_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ISSUE_READY = ready_q;
  assign OUT_VALID   = valid_q;
  assign OUT         = out_q;
  assign ILLEGAL     = ill_q;
  assign TIMEOUT_ERR = terr_q;

endmodule

// File: doc/fpu_result_collector.md
# fpu_result_collector

Parametrised, registered successor to the FPU combinational result multiplexer. It accepts one FPU operation issue at a time and decodes FPU_Control to a result-unit index. It then waits for that unit's result handshake, registers the selected result, and presents it on a valid/ready output port. Units that never answer are reported as a timeout, and undefined opcodes are reported as illegal. It sits between the FPU functional units and the floating-point register-file writeback, and it allows multi-cycle units (div, conversions) without stalling on a combinational path.

## Interface
Parameters:
- DATA_W, 32, result width in bits
- N_UNITS, 6, number of result units; legal range 6..8
- TIMEOUT, 64, maximum WAIT cycles before a timeout error; legal range 2..2^16

Ports:
- CLK  input  1  clock, rising-edge
- RST  input  1  asynchronous, active-low reset
- ISSUE_VALID  input  1  an operation is being issued this cycle
- FPU_Control  input  4  opcode of the issued operation
- ISSUE_READY  output  1  collector can accept an issue
- UNIT_DATA  input  N_UNITS*DATA_W  result buses; unit i occupies bits [i*DATA_W +: DATA_W]
- UNIT_VALID  input  N_UNITS  per-unit result-valid pulses
- OUT  output  DATA_W  registered result
- OUT_VALID  output  1  OUT holds a result
- OUT_READY  input  1  writeback consumes OUT
- ILLEGAL  output  1  the current OUT is from an undefined opcode
- TIMEOUT_ERR  output  1  the current OUT is from a timed-out unit

## Operation
- Opcode decode:
  - 0,1 -> unit 0 (add/sub)
  - 2 -> unit 1 (mul)
  - 3 -> unit 2 (div)
  - 4-6 -> unit 3 (compare)
  - 7-10 -> unit 4 (convert)
  - 11-13 -> unit 5 (sign-injection)
  - 14 -> unit 6 if N_UNITS>=7, else illegal
  - 15 -> unit 7 if N_UNITS==8, else illegal
- FSM states:
  - IDLE:
    - ISSUE_READY=1.
    - On ISSUE_VALID with a legal opcode: latch the unit index into SEL, clear the cycle counter, and go to WAIT.
    - On ISSUE_VALID with an illegal opcode: load OUT=0, set ILLEGAL=1, and go to HOLD.
  - WAIT:
    - ISSUE_READY=0; the counter increments each cycle.
    - If UNIT_VALID[SEL]=1: load OUT=UNIT_DATA[SEL], clear both flags, and go to HOLD.
    - Otherwise, if the counter equals TIMEOUT-1: load OUT=0, set TIMEOUT_ERR=1, and go to HOLD.
  - HOLD:
    - OUT_VALID=1 and ISSUE_READY=0.
    - OUT, ILLEGAL and TIMEOUT_ERR stay stable until OUT_READY=1.
    - When OUT_READY=1, go to IDLE.
- UNIT_VALID bits for units other than SEL are ignored. All UNIT_VALID bits are ignored in IDLE and HOLD; late or spurious responses are dropped.
- The counter is ceil(log2(TIMEOUT)) bits wide and never wraps; it saturates at TIMEOUT-1.
- ILLEGAL and TIMEOUT_ERR are mutually exclusive.

## Timing
- Reset (RST=0, at any time, including mid-WAIT or mid-HOLD):
  - State goes to IDLE.
  - OUT=0, OUT_VALID=0, ILLEGAL=0, TIMEOUT_ERR=0, counter=0, SEL=0.
  - ISSUE_READY is forced 0 while RST=0 and is 1 from the first CLK edge after release.
  - Any in-flight result is discarded.
- ISSUE_READY and OUT_VALID are decoded from registered state only; they have no combinational path from inputs.
- An issue is accepted at edge T when ISSUE_VALID & ISSUE_READY.
- Legal-op latency:
  - Units assert UNIT_VALID no earlier than cycle T+1.
  - If UNIT_VALID[SEL] is high in cycle T+k, then OUT/OUT_VALID are valid from T+k+1.
  - The minimum issue-to-OUT_VALID latency is 2 cycles.
- Illegal-op latency: OUT_VALID=1 from T+1.
- Timeout:
  - With no valid response, TIMEOUT_ERR/OUT_VALID rise TIMEOUT+1 cycles after T.
  - If UNIT_VALID[SEL] arrives in the same cycle that the counter equals TIMEOUT-1, the valid result wins and no error is flagged.
- Handshake:
  - The transfer occurs at the edge where OUT_VALID & OUT_READY are both 1; OUT_VALID falls on the next cycle.
  - The next issue can be accepted one cycle after the transfer.
  - Back-to-back throughput is 1 operation per (latency+1) cycles.
- OUT holds its last value after the transfer. It is cleared only by reset or overwritten by the next load; consumers qualify it with OUT_VALID.

## Test plan
- Reset mid-WAIT:
  - Issue op 3.
  - Assert RST=0 for 2 cycles before the unit-2 valid arrives, then release.
  - Pulse UNIT_VALID[2].
  - Required: OUT_VALID stays 0, ISSUE_READY=1 after release, and the late pulse is ignored.
- Sweep all 16 opcodes with N_UNITS=6; each unit i drives 0x3F80_0000+i and pulses UNIT_VALID[i] 1 cycle after issue, with OUT_READY=1.
  - Ops 0-13 must return their decoded unit's value with OUT_VALID at T+2.
  - Ops 14 and 15 must return OUT=0 with ILLEGAL=1 at T+1.
- Repeat the sweep with N_UNITS=8: ops 14 and 15 must return units 6 and 7 with ILLEGAL=0.
- Wrong-unit response and timeout, with TIMEOUT=8:
  - Issue op 2 and pulse only UNIT_VALID[0].
  - Required: OUT=0 and TIMEOUT_ERR=1 with OUT_VALID rising exactly 9 cycles after issue.
  - Repeat, pulsing UNIT_VALID[1] in the final WAIT cycle: required OUT=unit-1 data and TIMEOUT_ERR=0.
- Backpressure:
  - Hold OUT_READY=0 for 5 cycles after a mul result 0x4049_0FDB, while UNIT_DATA changes and ISSUE_VALID=1.
  - Required: OUT stays 0x4049_0FDB and ISSUE_READY stays 0.
  - Release OUT_READY: the transfer completes and a new issue is accepted on the next cycle.
